// File: rtl/lfsr_galois_param.sv
// Parametrised LFSR (Galois or Fibonacci topology) with step enable, runtime seed load,
// all-zero lock-up recovery and measurement of the last completed period length.
module lfsr_galois_param #(
  parameter int                 WIDTH = 5,
  parameter logic [WIDTH-1:0]   TAPS  = 5'b00100,
  parameter logic [WIDTH-1:0]   SEED  = 5'b00001,
  parameter int                 MODE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] S,
  output logic             fb_out,
  output logic             lockup,
  output logic             wrap,
  output logic [WIDTH-1:0] period_len
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] next_s;
  logic             fb;

  assign fb_out = S[WIDTH-1];

  // Next state of one LFSR step; TAPS[0] never contributes since the +1 term is implicit.
  always_comb begin
    next_s = '0;
    fb     = 1'b0;
    if (MODE == 0) begin
      next_s[0] = S[WIDTH-1];
      for (int i = 1; i < WIDTH; i++) begin
        next_s[i] = S[i-1] ^ (TAPS[i] & S[WIDTH-1]);
      end
    end else begin
      fb = S[WIDTH-1];
      for (int i = 1; i < WIDTH; i++) begin
        fb = fb ^ (TAPS[i] & S[i-1]);
      end
      next_s = {S[WIDTH-2:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      S          <= SEED;
      start      <= SEED;
      count      <= '0;
      period_len <= '0;
      lockup     <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      lockup <= 1'b0;
      wrap   <= 1'b0;
      if (load) begin
        // A zero seed would freeze the register, so it is swapped for SEED and flagged.
        count <= '0;
        if (seed_in != '0) begin
          S     <= seed_in;
          start <= seed_in;
        end else begin
          S      <= SEED;
          start  <= SEED;
          lockup <= 1'b1;
        end
      end else if (en) begin
        if (S == '0) begin
          S      <= SEED;
          start  <= SEED;
          count  <= '0;
          lockup <= 1'b1;
        end else begin
          S <= next_s;
          // Period is counted in steps since the last start/wrap; idle cycles do not count.
          if (next_s == start) begin
            wrap       <= 1'b1;
            period_len <= count + ONE;
            count      <= '0;
          end else begin
            count <= count + ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_galois_param.sv
// Scoreboard bench for lfsr_galois_param: three instances (Galois, Fibonacci, non-primitive 4-bit)
// share stimulus and are checked against a polynomial-arithmetic reference model.
module tb_lfsr_galois_param;

  typedef struct packed {
    logic [31:0] s;
    logic        lk;
    logic        wr;
    logic [31:0] pl;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, en, load;
  logic [4:0] seed_in;

  logic [4:0] s_a, pl_a, s_b, pl_b;
  logic [3:0] s_c, pl_c;
  logic       fb_a, lk_a, wr_a, fb_b, lk_b, wr_b, fb_c, lk_c, wr_c;

  exp_t q_a[$], q_b[$], q_c[$];

  int n_checks = 0;
  int n_fail   = 0;

  int          p_w[3], p_mode[3];
  int unsigned p_taps[3], p_seed[3];
  int unsigned m_s[3], m_start[3], m_cnt[3], m_pl[3];

  always #5 clk = ~clk;

  lfsr_galois_param #(.WIDTH(5), .TAPS(5'b00100), .SEED(5'b00001), .MODE(0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in),
    .S(s_a), .fb_out(fb_a), .lockup(lk_a), .wrap(wr_a), .period_len(pl_a));

  lfsr_galois_param #(.WIDTH(5), .TAPS(5'b00100), .SEED(5'b00001), .MODE(1)) dut_b (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in),
    .S(s_b), .fb_out(fb_b), .lockup(lk_b), .wrap(wr_b), .period_len(pl_b));

  lfsr_galois_param #(.WIDTH(4), .TAPS(4'b0000), .SEED(4'h1), .MODE(0)) dut_c (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in[3:0]),
    .S(s_c), .fb_out(fb_c), .lockup(lk_c), .wrap(wr_c), .period_len(pl_c));

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Galois step is multiplication by x modulo p(x); Fibonacci step shifts in the parity of tapped bits.
  function automatic int unsigned modelStep(int k, int unsigned s);
    longint unsigned mask, r, m;
    mask = (64'd1 << p_w[k]) - 64'd1;
    if (p_mode[k] == 0) begin
      r = longint'(s) << 1;
      if (r[p_w[k]]) r = r ^ longint'(p_taps[k] | 1);
    end else begin
      m = longint'(p_taps[k] >> 1) ^ (64'd1 << (p_w[k] - 1));
      r = (longint'(s) << 1) | longint'($countones(longint'(s) & m) & 1);
    end
    return int'(r & mask);
  endfunction

  function automatic exp_t modelCycle(int k, logic r, logic l, logic e, int unsigned sd);
    exp_t        x;
    int unsigned mask, v, n;
    mask = (p_w[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << p_w[k]) - 1);
    x = '0;
    if (r) begin
      m_s[k] = p_seed[k]; m_start[k] = p_seed[k]; m_cnt[k] = 0; m_pl[k] = 0;
    end else if (l) begin
      v = sd & mask;
      m_cnt[k] = 0;
      if (v != 0) begin
        m_s[k] = v; m_start[k] = v;
      end else begin
        m_s[k] = p_seed[k]; m_start[k] = p_seed[k]; x.lk = 1'b1;
      end
    end else if (e) begin
      if (m_s[k] == 0) begin
        m_s[k] = p_seed[k]; m_start[k] = p_seed[k]; m_cnt[k] = 0; x.lk = 1'b1;
      end else begin
        n = modelStep(k, m_s[k]);
        m_s[k] = n;
        if (n == m_start[k]) begin
          x.wr = 1'b1; m_pl[k] = m_cnt[k] + 1; m_cnt[k] = 0;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
    x.s  = m_s[k];
    x.pl = m_pl[k];
    return x;
  endfunction

  task automatic applyStimulus(input logic r, input logic l, input logic e, input logic [4:0] sd);
    @(negedge clk);
    reset = r; load = l; en = e; seed_in = sd;
    q_a.push_back(modelCycle(0, r, l, e, 32'(sd)));
    q_b.push_back(modelCycle(1, r, l, e, 32'(sd)));
    q_c.push_back(modelCycle(2, r, l, e, 32'(sd)));
  endtask

  task automatic compareItem(input string tag, input int w, input exp_t x, input logic [31:0] s,
                             input logic fb, input logic lk, input logic wr, input logic [31:0] pl);
    checkOutput({tag, ".S"}, s, x.s);
    checkOutput({tag, ".fb_out"}, 32'(fb), 32'((x.s >> (w - 1)) & 1));
    checkOutput({tag, ".lockup"}, 32'(lk), 32'(x.lk));
    checkOutput({tag, ".wrap"}, 32'(wr), 32'(x.wr));
    checkOutput({tag, ".period_len"}, pl, x.pl);
  endtask

  // Monitor: every clock the DUTs present a new registered state; compare it just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin x = q_a.pop_front(); compareItem("galois", 5, x, 32'(s_a), fb_a, lk_a, wr_a, 32'(pl_a)); end
      if (q_b.size() > 0) begin x = q_b.pop_front(); compareItem("fibonacci", 5, x, 32'(s_b), fb_b, lk_b, wr_b, 32'(pl_b)); end
      if (q_c.size() > 0) begin x = q_c.pop_front(); compareItem("nonprim4", 4, x, 32'(s_c), fb_c, lk_c, wr_c, 32'(pl_c)); end
    end
  end

  initial begin
    bit seen[32];
    int distinct;
    int drain;
    logic [4:0] sd;

    p_w    = '{5, 5, 4};
    p_mode = '{0, 1, 0};
    p_taps = '{32'h4, 32'h4, 32'h0};
    p_seed = '{32'h1, 32'h1, 32'h1};
    reset = 1'b1; en = 1'b0; load = 1'b0; seed_in = '0;

    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);

    // Free run from reset: one full period, tracking every state the Galois instance visits.
    for (int i = 0; i < 32; i++) seen[i] = 1'b0;
    for (int i = 1; i <= 62; i++) begin
      applyStimulus(0, 0, 1, 0);
      @(posedge clk);
      #2;
      if (i <= 31) seen[s_a] = 1'b1;
      if (i == 31 || i == 62) begin
        checkOutput("galois.wrap_step", 32'(wr_a), 32'd1);
        checkOutput("galois.period31", 32'(pl_a), 32'd31);
        checkOutput("galois.back_to_seed", 32'(s_a), 32'd1);
        checkOutput("fibonacci.period31", 32'(pl_b), 32'd31);
        checkOutput("nonprim4.period4", 32'(pl_c), 32'd4);
      end
    end
    distinct = 0;
    for (int i = 1; i < 32; i++) if (seen[i]) distinct++;
    checkOutput("galois.distinct_states", 32'(distinct), 32'd31);
    checkOutput("galois.zero_never_seen", 32'(seen[0]), 32'd0);

    // Zero seed load, then load together with en, then a full period from the new start.
    applyStimulus(0, 1, 0, 5'h00);
    applyStimulus(0, 1, 1, 5'h13);
    for (int i = 0; i < 31; i++) applyStimulus(0, 0, 1, 0);
    @(posedge clk);
    #2;
    checkOutput("galois.wrap_at_13", 32'(s_a), 32'h13);

    // Idle cycles interleaved with steps must not disturb period measurement.
    for (int i = 0; i < 140; i++) applyStimulus(0, 0, (i % 4 == 0) || (i % 4 == 3), 0);

    for (int i = 0; i < 2000; i++) begin
      sd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 3) != 0, sd);
    end

    // Reset overriding simultaneous load and en mid-sequence.
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 1, 1, 5'h13);
    applyStimulus(0, 0, 0, 0);

    drain = 0;
    while ((q_a.size() > 0 || q_b.size() > 0 || q_c.size() > 0) && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    if (q_a.size() > 0 || q_b.size() > 0 || q_c.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain pending=%0d expected=0", q_a.size() + q_b.size() + q_c.size());
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
